// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the packet trailer stage.
// Trailer length depends on PKT_TRAILER_LEN_EN.
package axis_pkt_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    TRL_LEN = 2'd1,
    TRL_SUM = 2'd2
  } trl_state_t;

`ifdef PKT_TRAILER_LEN_EN
  localparam int TRL_BEATS = 2;
`else
  localparam int TRL_BEATS = 1;
`endif

endpackage

// File: rtl/axis_out_reg.sv
// Single registered AXI-Stream output stage: {last, data} word plus valid,
// reloaded whenever the slot is empty or being drained this cycle.
module axis_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             ld,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  logic             valid_reg;
  logic [WIDTH:0]   word_reg;

  assign ld = !valid_reg || out_ready;

  // Without ld the beat on the bus is frozen; data is only overwritten on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      word_reg  <= '0;
    end else if (ld) begin
      valid_reg <= load;
      if (load) begin
        word_reg <= {load_last, load_data};
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = word_reg[WIDTH-1:0];
  assign out_last  = word_reg[WIDTH];

endmodule

// File: rtl/axis_pkt_trailer.sv
// Forwards packets unchanged and appends trailer beats ({count,} xor-sum).
// Optional length beat enabled by defining PKT_TRAILER_LEN_EN.
module axis_pkt_trailer
  import axis_pkt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S_AXIS_TVALID,
  input  logic [WIDTH-1:0] S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic             M_AXIS_TVALID,
  output logic [WIDTH-1:0] M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  output logic             pkt_done
);

  trl_state_t       state_reg, state_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
`ifdef PKT_TRAILER_LEN_EN
  logic [WIDTH-1:0] cnt_reg, cnt_next;
`endif
  logic             ld;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_last;
  logic             s_hs;
  logic             pkt_done_reg;

  // Upstream is only accepted while passing data, and never during reset.
  assign S_AXIS_TREADY = !rst && ld && (state_reg == PASS);
  assign s_hs          = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
`ifdef PKT_TRAILER_LEN_EN
    cnt_next   = cnt_reg;
`endif
    load       = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    case (state_reg)
      PASS: begin
        if (s_hs) begin
          load      = 1'b1;
          load_data = S_AXIS_TDATA;
          sum_next  = sum_reg ^ S_AXIS_TDATA;
`ifdef PKT_TRAILER_LEN_EN
          cnt_next  = cnt_reg + WIDTH'(1);
          if (S_AXIS_TLAST) state_next = TRL_LEN;
`else
          if (S_AXIS_TLAST) state_next = TRL_SUM;
`endif
        end
      end
`ifdef PKT_TRAILER_LEN_EN
      TRL_LEN: begin
        if (ld) begin
          load       = 1'b1;
          load_data  = cnt_reg;
          state_next = TRL_SUM;
        end
      end
`endif
      TRL_SUM: begin
        if (ld) begin
          load       = 1'b1;
          load_data  = sum_reg;
          load_last  = 1'b1;
          sum_next   = '0;
`ifdef PKT_TRAILER_LEN_EN
          cnt_next   = '0;
`endif
          state_next = PASS;
        end
      end
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= PASS;
      sum_reg      <= '0;
`ifdef PKT_TRAILER_LEN_EN
      cnt_reg      <= '0;
`endif
      pkt_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sum_reg      <= sum_next;
`ifdef PKT_TRAILER_LEN_EN
      cnt_reg      <= cnt_next;
`endif
      pkt_done_reg <= M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
    end
  end

  assign pkt_done = pkt_done_reg;

  axis_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .load_last(load_last),
    .ld       (ld),
    .out_valid(M_AXIS_TVALID),
    .out_data (M_AXIS_TDATA),
    .out_last (M_AXIS_TLAST),
    .out_ready(M_AXIS_TREADY)
  );

endmodule

// File: tb/tb_axis_pkt_trailer.sv
// Randomized bench for axis_pkt_trailer against a queue-based packet model.
module tb_axis_pkt_trailer;
  import axis_pkt_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic             pkt_done;

  axis_pkt_trailer #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .S_AXIS_TVALID(s_valid),
    .S_AXIS_TDATA (s_data),
    .S_AXIS_TLAST (s_last),
    .S_AXIS_TREADY(s_ready),
    .M_AXIS_TVALID(m_valid),
    .M_AXIS_TDATA (m_data),
    .M_AXIS_TLAST (m_last),
    .M_AXIS_TREADY(m_ready),
    .pkt_done     (pkt_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]       in_q[$];
  logic [8:0]       exp_q[$];
  logic [8:0]       log_q[$];
  logic [WIDTH-1:0] m_sum = '0;
  logic [WIDTH-1:0] m_cnt = '0;
  logic             expect_done = 1'b0;
  logic             prev_stall = 1'b0;
  logic [8:0]       prev_beat = '0;
  logic             s_acc_prev = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Packet-level model: payload passes through, trailer appended after the last beat.
  task automatic model_beat(logic [WIDTH-1:0] d, logic l);
    exp_q.push_back({1'b0, d});
    m_sum = m_sum ^ d;
    m_cnt = m_cnt + 8'd1;
    if (l) begin
      if (TRL_BEATS == 2) exp_q.push_back({1'b0, m_cnt});
      exp_q.push_back({1'b1, m_sum});
      m_sum = '0;
      m_cnt = '0;
    end
  endtask

  task automatic step(int vp, int rp);
    logic       s_hs;
    logic       m_hs;
    logic [8:0] e;
    @(negedge clk);
    if (s_valid && s_acc_prev) s_valid = 1'b0;
    if (!s_valid && in_q.size() > 0 && $urandom_range(99) < vp) begin
      e       = in_q.pop_front();
      s_valid = 1'b1;
      s_data  = e[7:0];
      s_last  = e[8];
    end
    m_ready = ($urandom_range(99) < rp);
    #1;
    if (prev_stall) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_beat", {m_last, m_data}, prev_beat);
    end
    chk("pkt_done", pkt_done, expect_done);
    m_hs = m_valid && m_ready;
    s_hs = s_valid && s_ready;
    if (m_hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", {m_last, m_data}, e);
      end
      log_q.push_back({m_last, m_data});
    end
    expect_done = m_hs && m_last;
    if (s_hs) model_beat(s_data, s_last);
    prev_stall = m_valid && !m_ready;
    prev_beat  = {m_last, m_data};
    s_acc_prev = s_hs;
  endtask

  task automatic run(int vp, int rp, int budget);
    int n;
    n = 0;
    while ((in_q.size() > 0 || (s_valid && !s_acc_prev) || exp_q.size() > 0) && n < budget) begin
      step(vp, rp);
      n++;
    end
    chk("drain", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_s_tready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_m_tvalid", m_valid, 0);
    chk("rst_m_tdata", m_data, 0);
    chk("rst_m_tlast", m_last, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("post_rst_s_tready", s_ready, 1);
    exp_q.delete();
    m_sum       = '0;
    m_cnt       = '0;
    expect_done = 1'b0;
    prev_stall  = 1'b0;
    s_acc_prev  = 1'b0;
  endtask

  initial begin
    logic [8:0] ref1[$];
    int         n;
    int         len;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Basic three-beat packet, exact output sequence
    log_q.delete();
    in_q.push_back(9'h001); in_q.push_back(9'h002); in_q.push_back(9'h104);
    run(100, 100, 50);
`ifdef PKT_TRAILER_LEN_EN
    ref1 = {9'h001, 9'h002, 9'h004, 9'h003, 9'h107};
`else
    ref1 = {9'h001, 9'h002, 9'h004, 9'h107};
`endif
    chk("basic_len", log_q.size(), ref1.size());
    for (int i = 0; i < ref1.size() && i < log_q.size(); i++) chk("basic_seq", log_q[i], ref1[i]);

    // Single-beat packet
    in_q.push_back(9'h1A5);
    run(100, 100, 50);

    // Output stall with a beat pending: upstream must be blocked
    in_q.push_back(9'h103);
    step(100, 0);
    for (int i = 0; i < 3; i++) begin
      step(100, 0);
      chk("stall_s_tready", s_ready, 0);
    end
    run(100, 100, 50);

    // Back-to-back packets
    log_q.delete();
    in_q.push_back(9'h110); in_q.push_back(9'h020); in_q.push_back(9'h10F);
    run(100, 100, 50);
    chk("b2b_last_sum", log_q[log_q.size()-1], 9'h12F);

    // 256-beat packet: count wraps to zero
    log_q.delete();
    for (int i = 0; i < 256; i++) in_q.push_back((i == 255) ? 9'h100 : 9'h000);
    run(100, 100, 400);
    chk("wrap_sum", log_q[log_q.size()-1], 9'h100);
    if (TRL_BEATS == 2) chk("wrap_cnt", log_q[log_q.size()-2], 9'h000);

    // Reset mid-packet with a beat pending on the output
    in_q.push_back(9'h001); in_q.push_back(9'h002);
    n = 0;
    while ((in_q.size() > 0 || !s_acc_prev) && n < 20) begin
      step(100, 100);
      n++;
    end
    step(0, 0);
    chk("pend_before_rst", m_valid, 1);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 100);
    chk("no_trailer_after_rst", log_q.size() > 0 && log_q[log_q.size()-1][8] == 1'b1 &&
        log_q[log_q.size()-1][7:0] == 8'h03, 0);
    in_q.push_back(9'h005); in_q.push_back(9'h106);
    run(100, 100, 50);

    // Randomized traffic with random backpressure
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) in_q.push_back({(i == len - 1), 8'($urandom)});
    end
    run(70, 60, 3000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_pkt_trailer.md
# axis_pkt_trailer

Downstream stage of the AXI-Stream byte FIFO. It consumes packets from the FIFO master port and forwards them unchanged. At the end of each packet it appends trailer beats: an optional beat count and an XOR checksum. The output drives the next AXI-Stream consumer through a single registered output stage.

## Interface
Parameters:
- WIDTH, 8, data width of both streams; also the width of the length and checksum accumulators.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- S_AXIS_TVALID  input  1  upstream beat valid; driven by the FIFO master side.
- S_AXIS_TDATA  input  WIDTH  upstream data.
- S_AXIS_TLAST  input  1  last beat of the upstream packet.
- S_AXIS_TREADY  output  1  this block accepts the upstream beat.
- M_AXIS_TVALID  output  1  output beat valid (registered).
- M_AXIS_TDATA  output  WIDTH  output data (registered).
- M_AXIS_TLAST  output  1  last beat of the output packet; asserted only on the final trailer beat.
- M_AXIS_TREADY  input  1  downstream ready.
- pkt_done  output  1  one-cycle pulse on the handshake of the final trailer beat.

## Operation
- Output register load enable: ld = !M_AXIS_TVALID || M_AXIS_TREADY.
- States are PASS, TRL_LEN and TRL_SUM. Reset state is PASS.
- PASS:
  - S_AXIS_TREADY = ld.
  - On an input handshake the beat is loaded into the output register with M_AXIS_TLAST=0 (input TLAST is stripped).
  - Same cycle: sum_q <= sum_q ^ TDATA; cnt_q <= cnt_q + 1, modulo 2^WIDTH.
  - If TLAST is set on that beat: go to TRL_LEN (macro on) or TRL_SUM (macro off).
- TRL_LEN:
  - S_AXIS_TREADY=0.
  - When ld: load cnt_q with TLAST=0, then go to TRL_SUM.
- TRL_SUM:
  - S_AXIS_TREADY=0.
  - When ld: load sum_q with TLAST=1, clear sum_q and cnt_q to 0, then go to PASS.
- Trailer values include the TLAST beat, because the accumulators update in the same cycle the beat is accepted.
- The length count wraps: 256 beats with WIDTH=8 reports 0x00.
- When ld=0, the output register holds TDATA, TLAST and TVALID stable.
- pkt_done = M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST, registered so it pulses the cycle after the handshake.

## Timing
- Reset values: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, pkt_done=0, sum_q=0, cnt_q=0, state=PASS.
- S_AXIS_TREADY is held 0 during the rst cycle and depends on ld after it.
- Latency: an input beat appears on M_AXIS one cycle after its handshake.
- Throughput: one beat per cycle in PASS with M_AXIS_TREADY held high.
- Inter-packet bubble on S_AXIS_TREADY: 2 cycles with the macro on, 1 cycle with it off.
- Back-to-back packets: the first beat of the next packet is accepted in the cycle after the TRL_SUM load. Its accumulation starts from the cleared values.
- Reset mid-packet: the partial packet is dropped, no trailer is emitted, and the output register is cleared even if a beat was pending.
- TVALID from upstream held without TLAST forever: the block keeps accumulating and the count wraps; no timeout.

## Configuration
- PKT_TRAILER_LEN_EN:
  - Defined: TRL_LEN exists and the trailer is {cnt, sum}, two beats.
  - Undefined: TRL_LEN and cnt_q are compiled out, and the trailer is the single sum beat.

## Structure
- Package axis_pkt_pkg holds:
  - the state enum typedef (PASS, TRL_LEN, TRL_SUM);
  - localparam TRL_BEATS = 2 or 1, selected by the macro.
- One sub-module is natural: axis_out_reg. It is the WIDTH+1-bit output register with valid and load-enable logic, and is instantiated once.

## Test plan
- WIDTH=8, macro on, input 0x01, 0x02, 0x04(TLAST), TREADY=1 -> output 0x01, 0x02, 0x04, 0x03, 0x07; TLAST only on 0x07; one pkt_done pulse.
- Single-beat packet 0xA5(TLAST) -> output 0xA5, 0x01, 0xA5(TLAST).
- M_AXIS_TREADY low for 3 cycles while 0x03 is presented -> TDATA/TVALID stable; S_AXIS_TREADY=0; no beat lost or duplicated.
- Two back-to-back packets {0x10(TLAST)} and {0x20, 0x0F(TLAST)} -> output 0x10, 0x01, 0x10, 0x20, 0x0F, 0x02, 0x2F; the second checksum is unaffected by the first packet.
- 256 beats of 0x00, last with TLAST -> length trailer 0x00, checksum 0x00; rst pulsed after 0x01, 0x02 of the next packet -> all outputs 0 and no trailer.
- Macro off: 0x01, 0x02, 0x04(TLAST) -> output 0x01, 0x02, 0x04, 0x07(TLAST).
